// File: rtl/mem_wb_writeback_pkg.sv
// Shared RISC-V pipeline constants, control opcodes and the MEM/WB register layout.
package riscv_pkg;

    localparam int XLEN  = 64;
    localparam int PC_W  = 8;
    localparam int RA_W  = 5;
    localparam int CNT_W = 32;

    localparam logic [RA_W-1:0] REG_X0 = '0;

    // Major opcodes decoded by the control unit.
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] wdata;
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_writeback_if.sv
// EX/MEM-to-writeback bundle: pipeline inputs, decode read addresses, write port and trace outputs.
interface mem_wb_writeback_if;
    import riscv_pkg::*;

    logic                  in_valid;
    logic [XLEN-1:0]       in_alu_result;
    logic [XLEN-1:0]       in_mem_data;
    logic [RA_W-1:0]       in_rd;
    logic                  in_regwrite;
    logic                  in_memtoreg;
    logic [PC_W-1:0]       in_pc;
    logic [31:0]           in_instr;
    logic                  stall;
    logic                  flush;
    logic [RA_W-1:0]       id_rs1;
    logic [RA_W-1:0]       id_rs2;

    logic [XLEN-1:0]       rf_wrt_data;
    logic [RA_W-1:0]       rf_rd;
    logic                  rf_regwrite;
    logic                  byp_rs1_hit;
    logic                  byp_rs2_hit;
    logic [XLEN-1:0]       byp_data;
    logic                  wb_valid;
    logic [PC_W-1:0]       wb_pc;
    logic [31:0]           wb_instr;
    logic [CNT_W-1:0]      retire_count;

    modport master (
        output in_valid, in_alu_result, in_mem_data, in_rd, in_regwrite, in_memtoreg,
               in_pc, in_instr, stall, flush, id_rs1, id_rs2,
        input  rf_wrt_data, rf_rd, rf_regwrite, byp_rs1_hit, byp_rs2_hit, byp_data,
               wb_valid, wb_pc, wb_instr, retire_count
    );

    modport slave (
        input  in_valid, in_alu_result, in_mem_data, in_rd, in_regwrite, in_memtoreg,
               in_pc, in_instr, stall, flush, id_rs1, id_rs2,
        output rf_wrt_data, rf_rd, rf_regwrite, byp_rs1_hit, byp_rs2_hit, byp_data,
               wb_valid, wb_pc, wb_instr, retire_count
    );

endinterface

// File: rtl/mem_wb_writeback_bypass.sv
// Decode-read vs committing-write comparators; purely combinational.
// No state, no backpressure; x0 never hits.
module wb_bypass
    import riscv_pkg::*;
(
    input  logic            regwrite,
    input  logic [RA_W-1:0] rd,
    input  logic [RA_W-1:0] rs1,
    input  logic [RA_W-1:0] rs2,
    output logic            rs1_hit,
    output logic            rs2_hit
);

    assign rs1_hit = regwrite && (rs1 == rd) && (rs1 != REG_X0);
    assign rs2_hit = regwrite && (rs2 == rd) && (rs2 != REG_X0);

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB register, writeback data select, register-file write port, bypass and retire counter.
// Capture at edge N drives the write port in cycle N; stall holds the slot, flush outranks stall.
module mem_wb_writeback
    import riscv_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    mem_wb_writeback_if.slave   bus
);

    mem_wb_t          wb_q, wb_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic             retiring;
    logic             regwrite_now;

    // done marks a slot that has already committed, so a stalled instruction writes/counts once.
    assign retiring     = wb_q.valid && !done_q;
    assign regwrite_now = retiring && wb_q.regwrite && (wb_q.rd != REG_X0);

    always_comb begin
        wb_d     = wb_q;
        done_d   = done_q;
        retire_d = retire_q + CNT_W'(retiring);
        if (bus.flush) begin
            wb_d   = '0;
            done_d = 1'b0;
        end else if (!bus.stall) begin
            wb_d.valid    = bus.in_valid;
            wb_d.regwrite = bus.in_regwrite;
            wb_d.rd       = bus.in_rd;
            wb_d.wdata    = bus.in_memtoreg ? bus.in_mem_data : bus.in_alu_result;
            wb_d.pc       = bus.in_pc;
            wb_d.instr    = bus.in_instr;
            done_d        = 1'b0;
        end else if (wb_q.valid) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q     <= '0;
            done_q   <= 1'b0;
            retire_q <= '0;
        end else begin
            wb_q     <= wb_d;
            done_q   <= done_d;
            retire_q <= retire_d;
        end
    end

    wb_bypass u_bypass (
        .regwrite (regwrite_now),
        .rd       (wb_q.rd),
        .rs1      (bus.id_rs1),
        .rs2      (bus.id_rs2),
        .rs1_hit  (bus.byp_rs1_hit),
        .rs2_hit  (bus.byp_rs2_hit)
    );

    // The count includes the instruction committing this cycle.
    assign bus.retire_count = retire_d;
    assign bus.rf_wrt_data  = wb_q.wdata;
    assign bus.rf_rd        = wb_q.rd;
    assign bus.rf_regwrite  = regwrite_now;
    assign bus.byp_data     = wb_q.wdata;
    assign bus.wb_valid     = wb_q.valid;
    assign bus.wb_pc        = wb_q.pc;
    assign bus.wb_instr     = wb_q.instr;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench: expected register-file writes are queued at issue and checked by a write monitor.
module tb_mem_wb_writeback;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] pc_ctr = 8'h10;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    mem_wb_writeback_if bus ();

    mem_wb_writeback dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1);
    end

    // Write monitor: every asserted write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && bus.rf_regwrite) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got rd=%0d data=%h, required no write",
                         bus.rf_rd, bus.rf_wrt_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.rf_rd !== mon_e.rd || bus.rf_wrt_data !== mon_e.data) begin
                    bad++;
                    $display("FAIL write_data: got rd=%0d data=%h, required rd=%0d data=%h",
                             bus.rf_rd, bus.rf_wrt_data, mon_e.rd, mon_e.data);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic issue(input logic v, input logic [63:0] alu, input logic [63:0] mem,
                         input logic [4:0] rd, input logic rw, input logic m2r,
                         input logic st, input logic fl);
        bus.in_valid      = v;
        bus.in_alu_result = alu;
        bus.in_mem_data   = mem;
        bus.in_rd         = rd;
        bus.in_regwrite   = rw;
        bus.in_memtoreg   = m2r;
        bus.in_pc         = pc_ctr;
        bus.in_instr      = {24'hABCDEF, pc_ctr};
        bus.stall         = st;
        bus.flush         = fl;
        if (v && rw && rd != 5'd0 && !st && !fl)
            exp_q.push_back(wr_t'({rd, (m2r ? mem : alu)}));
        pc_ctr++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_wb_valid"},    64'(bus.wb_valid),     64'd0);
        chk({nm, "_rf_regwrite"}, 64'(bus.rf_regwrite),  64'd0);
        chk({nm, "_rf_wrt_data"}, bus.rf_wrt_data,       64'd0);
        chk({nm, "_rf_rd"},       64'(bus.rf_rd),        64'd0);
        chk({nm, "_retire"},      64'(bus.retire_count), 64'd0);
        chk({nm, "_byp_hits"},    64'({bus.byp_rs1_hit, bus.byp_rs2_hit}), 64'd0);
        chk({nm, "_wb_pc"},       64'(bus.wb_pc),        64'd0);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_alu_result = 0; bus.in_mem_data = 0; bus.in_rd = 0;
        bus.in_regwrite = 0; bus.in_memtoreg = 0; bus.in_pc = 0; bus.in_instr = 0;
        bus.stall = 0; bus.flush = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;

        repeat (2) @(negedge clk);
        chk_all_zero("in_reset");
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("after_reset");

        // ALU writeback
        issue(1, 64'd42, 64'd0, 5'd5, 1, 0, 0, 0);
        chk("alu_regwrite", 64'(bus.rf_regwrite),  64'd1);
        chk("alu_retire",   64'(bus.retire_count), 64'd1);
        chk("alu_wb_valid", 64'(bus.wb_valid),     64'd1);
        chk("alu_wb_pc",    64'(bus.wb_pc),        64'h10);

        // Load writeback: -7 sign pattern from memory, ALU value ignored
        issue(1, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd3, 1, 1, 0, 0);
        chk("load_data",   bus.rf_wrt_data,       64'hFFFF_FFFF_FFFF_FFF9);
        chk("load_retire", 64'(bus.retire_count), 64'd2);

        // x0 destination: no write, no bypass, still retires
        bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
        issue(1, 64'd55, 64'd0, 5'd0, 1, 0, 0, 0);
        chk("x0_regwrite", 64'(bus.rf_regwrite),  64'd0);
        chk("x0_byp_hits", 64'({bus.byp_rs1_hit, bus.byp_rs2_hit}), 64'd0);
        chk("x0_retire",   64'(bus.retire_count), 64'd3);

        // Stall holding an rd=7 write for three cycles
        issue(1, 64'd77, 64'd0, 5'd7, 1, 0, 0, 0);
        chk("stall_first_regwrite", 64'(bus.rf_regwrite),  64'd1);
        chk("stall_first_retire",   64'(bus.retire_count), 64'd4);
        for (int i = 0; i < 3; i++) begin
            issue(1, 64'd88, 64'd0, 5'd8, 1, 0, 1, 0);
            chk("stall_hold_regwrite", 64'(bus.rf_regwrite),  64'd0);
            chk("stall_hold_retire",   64'(bus.retire_count), 64'd4);
            chk("stall_hold_rd",       64'(bus.rf_rd),        64'd7);
        end

        // Flush outranks stall
        issue(1, 64'd99, 64'd0, 5'd9, 1, 0, 1, 1);
        chk("flush_wb_valid", 64'(bus.wb_valid),     64'd0);
        chk("flush_regwrite", 64'(bus.rf_regwrite),  64'd0);
        chk("flush_retire",   64'(bus.retire_count), 64'd4);

        // Bypass
        bus.id_rs1 = 5'd4; bus.id_rs2 = 5'd6;
        issue(1, 64'd123, 64'd0, 5'd4, 1, 0, 0, 0);
        chk("byp_rs1_hit", 64'(bus.byp_rs1_hit), 64'd1);
        chk("byp_rs2_hit", 64'(bus.byp_rs2_hit), 64'd0);
        chk("byp_data",    bus.byp_data,         64'd123);
        bus.id_rs2 = 5'd4;
        #1;
        chk("byp_rs2_hit_same", 64'(bus.byp_rs2_hit), 64'd1);

        // Non-writing instruction to rd=4: counts, never bypasses
        issue(1, 64'd321, 64'd0, 5'd4, 0, 0, 0, 0);
        chk("nowrite_byp_rs1", 64'(bus.byp_rs1_hit),  64'd0);
        chk("nowrite_retire",  64'(bus.retire_count), 64'd6);

        // Reset mid-stall discards the held instruction
        issue(1, 64'd500, 64'd0, 5'd10, 1, 0, 0, 0);
        chk("pre_rst_retire", 64'(bus.retire_count), 64'd7);
        bus.stall = 1'b1;
        bus.id_rs1 = 5'd10;
        #1 rst = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        issue(1, 64'd600, 64'd0, 5'd11, 1, 0, 1, 0);
        chk("post_rst_regwrite", 64'(bus.rf_regwrite),  64'd0);
        chk("post_rst_wb_valid", 64'(bus.wb_valid),     64'd0);
        chk("post_rst_retire",   64'(bus.retire_count), 64'd0);
        issue(0, 64'd0, 64'd0, 5'd0, 0, 0, 0, 0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
